cdu_count_scheduler: RTL and testbench

CDU_COUNT_SCHEDULER -- requirements
Module: cdu_count_scheduler

---
 rtl/cdu_count_scheduler_pkg.sv | 45 ++++
 rtl/cdu_count_scheduler_pend_accum.sv | 64 ++++++
 rtl/cdu_count_scheduler.sv | 150 +++++++++++++++
 tb/tb_cdu_count_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cdu_count_scheduler_pkg.sv
// Shared types and helpers for the CDU count scheduler: FSM states,
// channel indices and accumulator saturation limits.
package cdu_count_scheduler_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned GAP_W  = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Largest positive value of a signed w-bit accumulator.
    function automatic int sat_max(input int unsigned w);
        int lim;
        lim = 1;
        lim = lim << (w - 1);
        return lim - 1;
    endfunction

    // Most negative value of a signed w-bit accumulator.
    function automatic int sat_min(input int unsigned w);
        int lim;
        lim = 1;
        lim = lim << (w - 1);
        return -lim;
    endfunction

    // Channel following ch in round-robin order A -> B -> C -> A.
    function automatic logic [1:0] rr_next_ch(input logic [1:0] ch);
        logic [1:0] nxt;
        case (ch)
            CH_A:    nxt = CH_B;
            CH_B:    nxt = CH_C;
            default: nxt = CH_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cdu_count_scheduler_pend_accum.sv
// Per-channel signed pending-count accumulator with saturation, sticky
// overflow flag and a zero command that overrides everything else.
module cdu_pend_accum
    import cdu_count_scheduler_pkg::*;
#(
    parameter int unsigned PEND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              dn,
    input  logic              zero,
    input  logic              ack_dec,
    input  logic              ack_inc,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    localparam int unsigned SUM_W = PEND_W + 2;

    logic signed [SUM_W-1:0]  pend_ext;
    logic signed [SUM_W-1:0]  step;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  lim_hi;
    logic signed [SUM_W-1:0]  lim_lo;
    logic        [PEND_W-1:0] pend_nxt;
    logic                     clip;

    // Full-precision sum of all contributions, then clip to the PEND_W range.
    always_comb begin
        pend_ext = SUM_W'($signed(pend));
        lim_hi   = SUM_W'(sat_max(PEND_W));
        lim_lo   = SUM_W'(sat_min(PEND_W));
        step     = '0;
        if (up && !dn) step = step + SUM_W'(1);
        if (dn && !up) step = step - SUM_W'(1);
        if (ack_inc)   step = step + SUM_W'(1);
        if (ack_dec)   step = step - SUM_W'(1);
        sum      = pend_ext + step;
        clip     = 1'b0;
        pend_nxt = sum[PEND_W-1:0];
        if (sum > lim_hi) begin
            pend_nxt = lim_hi[PEND_W-1:0];
            clip     = 1'b1;
        end else if (sum < lim_lo) begin
            pend_nxt = lim_lo[PEND_W-1:0];
            clip     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else if (zero) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            pend <= pend_nxt;
            ovf  <= ovf | clip;
        end
    end

endmodule

// File: rtl/cdu_count_scheduler.sv
// Schedules pending CDU counts from three gimbal channels onto a single
// AGC counter-increment request/acknowledge handshake, round-robin.
module cdu_count_scheduler
    import cdu_count_scheduler_pkg::*;
#(
    parameter int unsigned PEND_W     = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       CLOCKH,
    input  logic       rst,
    input  logic [2:0] CDU_UP,
    input  logic [2:0] CDU_DN,
    input  logic [2:0] CDUZ,
    input  logic       CNTACK,
    output logic       CNTREQ,
    output logic [1:0] CNTSEL,
    output logic       CNTDN,
    output logic [2:0] OVF,
    output logic       BUSY
);

    state_t                       state;
    state_t                       state_nxt;
    logic [1:0]                   rr;
    logic [1:0]                   rr_nxt;
    logic [GAP_W-1:0]             gap_cnt;
    logic [GAP_W-1:0]             gap_nxt;
    logic [1:0]                   sel_nxt;
    logic                         dn_nxt;
    logic                         req_nxt;
    logic                         busy_nxt;
    logic                         supp;
    logic                         supp_nxt;
    logic [NUM_CH-1:0]            ack_dec;
    logic [NUM_CH-1:0]            ack_inc;
    logic [NUM_CH-1:0]            nz;
    logic [NUM_CH-1:0][PEND_W-1:0] pend;
    logic [1:0]                   c0;
    logic [1:0]                   c1;
    logic [1:0]                   c2;
    logic [1:0]                   pick;
    logic                         pick_valid;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cdu_pend_accum #(
            .PEND_W (PEND_W)
        ) u_acc (
            .clk     (CLOCKH),
            .rst     (rst),
            .up      (CDU_UP[i]),
            .dn      (CDU_DN[i]),
            .zero    (CDUZ[i]),
            .ack_dec (ack_dec[i]),
            .ack_inc (ack_inc[i]),
            .pend    (pend[i]),
            .ovf     (OVF[i])
        );
        assign nz[i] = |pend[i];
    end

    // Round-robin pick: first nonzero channel starting at rr.
    always_comb begin
        c0         = rr;
        c1         = rr_next_ch(c0);
        c2         = rr_next_ch(c1);
        pick       = c0;
        pick_valid = |nz;
        if (nz[c2]) pick = c2;
        if (nz[c1]) pick = c1;
        if (nz[c0]) pick = c0;
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        gap_nxt   = gap_cnt;
        sel_nxt   = CNTSEL;
        dn_nxt    = CNTDN;
        supp_nxt  = supp;
        ack_dec   = '0;
        ack_inc   = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_nxt   = pick;
                    dn_nxt    = pend[pick][PEND_W-1];
                    rr_nxt    = rr_next_ch(pick);
                    supp_nxt  = CDUZ[pick];
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (CNTACK) begin
                    // Step follows the latched direction, not the current sign.
                    if (!supp) begin
                        ack_dec[CNTSEL] = !CNTDN;
                        ack_inc[CNTSEL] = CNTDN;
                    end
                    supp_nxt = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_GAP;
                        gap_nxt   = GAP_W'(GAP_CYCLES);
                    end
                end else begin
                    supp_nxt = supp | CDUZ[CNTSEL];
                end
            end
            ST_GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gap_nxt   = '0;
                supp_nxt  = 1'b0;
            end
        endcase
        req_nxt  = (state_nxt == ST_REQ);
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr      <= CH_A;
            gap_cnt <= '0;
            supp    <= 1'b0;
            CNTREQ  <= 1'b0;
            CNTSEL  <= CH_A;
            CNTDN   <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr      <= rr_nxt;
            gap_cnt <= gap_nxt;
            supp    <= supp_nxt;
            CNTREQ  <= req_nxt;
            CNTSEL  <= sel_nxt;
            CNTDN   <= dn_nxt;
            BUSY    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_cdu_count_scheduler.sv
// Directed self-checking bench for cdu_count_scheduler (PEND_W=4, GAP_CYCLES=2).
module tb_cdu_count_scheduler;

    logic       CLOCKH;
    logic       rst;
    logic [2:0] CDU_UP;
    logic [2:0] CDU_DN;
    logic [2:0] CDUZ;
    logic       CNTACK;
    logic       CNTREQ;
    logic [1:0] CNTSEL;
    logic       CNTDN;
    logic [2:0] OVF;
    logic       BUSY;

    int n_checks = 0;
    int n_pass   = 0;

    cdu_count_scheduler #(
        .PEND_W     (4),
        .GAP_CYCLES (2)
    ) dut (
        .CLOCKH (CLOCKH),
        .rst    (rst),
        .CDU_UP (CDU_UP),
        .CDU_DN (CDU_DN),
        .CDUZ   (CDUZ),
        .CNTACK (CNTACK),
        .CNTREQ (CNTREQ),
        .CNTSEL (CNTSEL),
        .CNTDN  (CNTDN),
        .OVF    (OVF),
        .BUSY   (BUSY)
    );

    initial CLOCKH = 1'b0;
    always #5 CLOCKH = ~CLOCKH;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [3:0] pend_of(input int i);
        return dut.pend[2'(i)];
    endfunction

    task automatic tick();
        @(posedge CLOCKH);
        #1;
    endtask

    task automatic do_reset();
        CDU_UP = '0; CDU_DN = '0; CDUZ = '0; CNTACK = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 20 && !CNTREQ; k++) tick();
        chk(tag, 32'(CNTREQ), 32'd1);
    endtask

    task automatic ack();
        CNTACK = 1'b1;
        tick();
        CNTACK = 1'b0;
    endtask

    initial begin
        int lows;
        int highs;
        logic [1:0] exp_sel [3];
        logic       exp_dn  [3];

        // Reset state
        CDU_UP = '0; CDU_DN = '0; CDUZ = '0; CNTACK = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_req",  32'(CNTREQ), 32'd0);
        chk("rst_sel",  32'(CNTSEL), 32'd0);
        chk("rst_dn",   32'(CNTDN),  32'd0);
        chk("rst_busy", 32'(BUSY),   32'd0);
        chk("rst_ovf",  32'(OVF),    32'd0);
        chk("rst_pend", 32'({pend_of(0), pend_of(1), pend_of(2)}), 32'd0);
        rst = 1'b0;
        tick();

        // Three UP pulses on B, ACK two clocks after each rise
        do_reset();
        CDU_UP = 3'b010;
        tick(); tick(); tick();
        CDU_UP = '0;
        for (int g = 0; g < 3; g++) begin
            wait_req($sformatf("b_req%0d", g));
            chk($sformatf("b_sel%0d", g), 32'(CNTSEL), 32'd1);
            chk($sformatf("b_dn%0d", g),  32'(CNTDN),  32'd0);
            tick();
            chk($sformatf("b_hold%0d", g), 32'(CNTREQ), 32'd1);
            ack();
            lows = 0;
            for (int k = 0; k < 12 && !CNTREQ; k++) begin
                lows++;
                tick();
            end
            // GAP_CYCLES idle clocks plus one selection clock
            if (g < 2) chk($sformatf("b_gap%0d", g), 32'(lows), 32'd3);
        end
        chk("b_final", 32'(pend_of(1)), 32'd0);

        // Simultaneous A=+1, B=-1, C=+1 with immediate ACKs
        do_reset();
        CDU_UP = 3'b101; CDU_DN = 3'b010;
        tick();
        CDU_UP = '0; CDU_DN = '0;
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2;
        exp_dn[0]  = 1'b0; exp_dn[1]  = 1'b1; exp_dn[2]  = 1'b0;
        for (int g = 0; g < 3; g++) begin
            wait_req($sformatf("rr_req%0d", g));
            chk($sformatf("rr_sel%0d", g), 32'(CNTSEL), 32'(exp_sel[g]));
            chk($sformatf("rr_dn%0d", g),  32'(CNTDN),  32'(exp_dn[g]));
            ack();
        end
        chk("rr_pend", 32'({pend_of(0), pend_of(1), pend_of(2)}), 32'd0);

        // Saturation: 9 UP on A (+7) and 9 DN on C (-8), no ACK
        do_reset();
        CDU_UP = 3'b001; CDU_DN = 3'b100;
        for (int k = 0; k < 9; k++) tick();
        CDU_UP = '0; CDU_DN = '0;
        tick();
        chk("sat_a",   32'(pend_of(0)), 32'h7);
        chk("sat_c",   32'(pend_of(2)), 32'h8);
        chk("sat_ovf", 32'(OVF),        32'b101);
        chk("sat_req", 32'(CNTREQ),     32'd1);
        chk("sat_sel", 32'(CNTSEL),     32'd0);
        CDUZ = 3'b001;
        tick();
        CDUZ = '0;
        chk("z_a",   32'(pend_of(0)), 32'd0);
        chk("z_ovf", 32'(OVF),        32'b100);
        chk("z_req", 32'(CNTREQ),     32'd1);
        ack();
        chk("z_ack_a", 32'(pend_of(0)), 32'd0);
        wait_req("sat_creq");
        chk("sat_csel", 32'(CNTSEL), 32'd2);
        chk("sat_cdn",  32'(CNTDN),  32'd1);

        // CDUZ on the selected channel while requesting
        do_reset();
        CDU_UP = 3'b100;
        tick(); tick();
        CDU_UP = '0;
        wait_req("cz_req");
        chk("cz_sel", 32'(CNTSEL), 32'd2);
        CDUZ = 3'b100;
        tick();
        CDUZ = '0;
        tick();
        chk("cz_hold", 32'(CNTREQ),     32'd1);
        chk("cz_zero", 32'(pend_of(2)), 32'd0);
        ack();
        chk("cz_drop", 32'(CNTREQ), 32'd0);
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            if (CNTREQ) highs++;
            tick();
        end
        chk("cz_after", 32'(pend_of(2)), 32'd0);
        chk("cz_noreq", 32'(highs),      32'd0);

        // UP and DN together on A cancel
        do_reset();
        CDU_UP = 3'b001; CDU_DN = 3'b001;
        tick();
        CDU_UP = '0; CDU_DN = '0;
        highs = 0;
        for (int k = 0; k < 5; k++) begin
            if (CNTREQ) highs++;
            tick();
        end
        chk("cancel_a",   32'(pend_of(0)), 32'd0);
        chk("cancel_req", 32'(highs),      32'd0);

        // Asynchronous reset mid-request
        do_reset();
        CDU_UP = 3'b001;
        for (int k = 0; k < 5; k++) tick();
        CDU_UP = '0;
        chk("ar_a5",  32'(pend_of(0)), 32'd5);
        chk("ar_req", 32'(CNTREQ),     32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_async_req",  32'(CNTREQ), 32'd0);
        chk("ar_async_busy", 32'(BUSY),   32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("ar_a0",   32'(pend_of(0)), 32'd0);
        chk("ar_idle", 32'(CNTREQ),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
